// File: rtl/tls_pkg.sv
// rtl/tls_pkg.sv - shared constants and types for the traffic-light command sequencer
//
// Purpose: opcode encodings, default field width, default phase durations and
//          the sequencer state enum, shared by tls_cmd_decode and tls_cmd_sequencer.
// Ports:   none (package).
package tls_pkg;

  localparam int TLS_CNT_W = 4;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_STOP = 2'b10;
  localparam logic [1:0] OP_JUMP = 2'b11;

  localparam logic [TLS_CNT_W-1:0] TLS_DEF_G = 4'd5;
  localparam logic [TLS_CNT_W-1:0] TLS_DEF_Y = 4'd2;
  localparam logic [TLS_CNT_W-1:0] TLS_DEF_R = 4'd6;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

endpackage

// File: rtl/tls_cmd_decode.sv
// rtl/tls_cmd_decode.sv - combinational opcode/field decoder for the command sequencer
//
// Purpose: splits cmd_data into G/Y/R duration fields and classifies the opcode.
//          Qualification with the handshake is left to the caller.
// Ports:
//   cmd_op      in   opcode (OP_NOP/OP_SET/OP_STOP/OP_JUMP)
//   cmd_data    in   {G,Y,R} for SET
//   g_field     out  green duration field (MSBs)
//   y_field     out  yellow duration field
//   r_field     out  red duration field (LSBs)
//   is_set_ok   out  SET with all fields non-zero
//   is_set_bad  out  SET with at least one zero field
//   is_stop     out  STOP opcode
//   is_jump     out  JUMP opcode
module tls_cmd_decode
  import tls_pkg::*;
#(
  parameter int CNT_W = TLS_CNT_W
) (
  input  logic [1:0]         cmd_op,
  input  logic [3*CNT_W-1:0] cmd_data,
  output logic [CNT_W-1:0]   g_field,
  output logic [CNT_W-1:0]   y_field,
  output logic [CNT_W-1:0]   r_field,
  output logic               is_set_ok,
  output logic               is_set_bad,
  output logic               is_stop,
  output logic               is_jump
);

  logic is_set;
  logic any_zero;

  assign g_field = cmd_data[3*CNT_W-1:2*CNT_W];
  assign y_field = cmd_data[2*CNT_W-1:CNT_W];
  assign r_field = cmd_data[CNT_W-1:0];

  // A zero duration would stall the controller in that phase, so it is illegal.
  assign any_zero   = (g_field == '0) || (y_field == '0) || (r_field == '0);
  assign is_set     = (cmd_op == OP_SET);
  assign is_set_ok  = is_set && !any_zero;
  assign is_set_bad = is_set && any_zero;
  assign is_stop    = (cmd_op == OP_STOP);
  assign is_jump    = (cmd_op == OP_JUMP);

endmodule

// File: rtl/tls_cmd_sequencer.sv
// rtl/tls_cmd_sequencer.sv - command front-end driving Set/Stop/Jump and durations of the traffic-light controller
//
// Purpose: accepts opcode commands over valid/ready, loads default durations
//          after reset, rejects zero durations, defers Jump while Stop is held.
//          Optional status counters are built when TLS_CMD_STATUS_EN is defined.
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   cmd_valid/cmd_ready command handshake (ready depends on state only)
//   cmd_op, cmd_data    opcode and payload
//   err_clr             clears err_o
//   set_o, jump_o       one-cycle pulses to the controller
//   stop_o              Stop level to the controller
//   gin_o/yin_o/rin_o   registered phase durations
//   err_o               sticky: a SET was rejected
//   acc_cnt, rej_cnt    (TLS_CMD_STATUS_EN) saturating accepted/rejected counters
module tls_cmd_sequencer
  import tls_pkg::*;
#(
  parameter int               CNT_W = TLS_CNT_W,
  parameter logic [CNT_W-1:0] DEF_G = CNT_W'(TLS_DEF_G),
  parameter logic [CNT_W-1:0] DEF_Y = CNT_W'(TLS_DEF_Y),
  parameter logic [CNT_W-1:0] DEF_R = CNT_W'(TLS_DEF_R)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [3*CNT_W-1:0] cmd_data,
  input  logic               err_clr,
  output logic               set_o,
  output logic               stop_o,
  output logic               jump_o,
  output logic [CNT_W-1:0]   gin_o,
  output logic [CNT_W-1:0]   yin_o,
  output logic [CNT_W-1:0]   rin_o,
  output logic               err_o
`ifdef TLS_CMD_STATUS_EN
  ,
  output logic [7:0]         acc_cnt,
  output logic [7:0]         rej_cnt
`endif
);

  state_t           state, state_next;
  logic             pending_jump, pend_next;
  logic             set_next, jump_next, stop_next, err_next;
  logic [CNT_W-1:0] g_next, y_next, r_next;
  logic [CNT_W-1:0] g_field, y_field, r_field;
  logic             is_set_ok, is_set_bad, is_stop, is_jump;
  logic             accept;
  logic             pend_release;

  tls_cmd_decode #(.CNT_W(CNT_W)) u_decode (
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .g_field    (g_field),
    .y_field    (y_field),
    .r_field    (r_field),
    .is_set_ok  (is_set_ok),
    .is_set_bad (is_set_bad),
    .is_stop    (is_stop),
    .is_jump    (is_jump)
  );

  assign cmd_ready    = (state == IDLE);
  assign accept       = cmd_valid && cmd_ready;
  // Release decision uses the registered stop level, so the deferred pulse
  // lands in the cycle after stop_o has been seen low.
  assign pend_release = pending_jump && !stop_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    set_next   = 1'b0;
    jump_next  = 1'b0;
    stop_next  = stop_o;
    pend_next  = pending_jump;
    err_next   = err_o;
    g_next     = gin_o;
    y_next     = yin_o;
    r_next     = rin_o;

    case (state)
      INIT: begin
        // Durations already hold the defaults; announce them once.
        state_next = IDLE;
        set_next   = 1'b1;
      end
      default: state_next = IDLE;
    endcase

    if (pend_release) begin
      jump_next = 1'b1;
      pend_next = 1'b0;
    end

    if (accept) begin
      if (is_stop) begin
        stop_next = cmd_data[0];
      end
      if (is_jump) begin
        if (!stop_o) begin
          jump_next = 1'b1;
        end else begin
          pend_next = 1'b1;
        end
      end
      // A valid SET restarts the controller, so it supersedes any jump.
      if (is_set_ok) begin
        g_next    = g_field;
        y_next    = y_field;
        r_next    = r_field;
        set_next  = 1'b1;
        jump_next = 1'b0;
        pend_next = 1'b0;
      end
    end

    if (err_clr) begin
      err_next = 1'b0;
    end
    if (accept && is_set_bad) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      set_o        <= 1'b0;
      stop_o       <= 1'b0;
      jump_o       <= 1'b0;
      pending_jump <= 1'b0;
      err_o        <= 1'b0;
      gin_o        <= DEF_G;
      yin_o        <= DEF_Y;
      rin_o        <= DEF_R;
    end else begin
      set_o        <= set_next;
      stop_o       <= stop_next;
      jump_o       <= jump_next;
      pending_jump <= pend_next;
      err_o        <= err_next;
      gin_o        <= g_next;
      yin_o        <= y_next;
      rin_o        <= r_next;
    end
  end

`ifdef TLS_CMD_STATUS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt <= 8'd0;
      rej_cnt <= 8'd0;
    end else begin
      if (accept && (acc_cnt != 8'hFF)) begin
        acc_cnt <= acc_cnt + 8'd1;
      end
      if (accept && is_set_bad && (rej_cnt != 8'hFF)) begin
        rej_cnt <= rej_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: doc/tls_cmd_sequencer.md
Name: tls_cmd_sequencer

Overview:
- Upstream command front-end for the traffic-light controller.
- Accepts opcode commands over a valid/ready handshake and drives the controller's Set, Stop and Jump controls plus its Gin/Yin/Rin duration inputs.
- Guarantees durations are stable whenever Set is high, loads safe defaults after reset, rejects illegal zero durations, and defers Jump while Stop is held.

Parameters:
- CNT_W, 4: width of each phase duration field.
- DEF_G, 4'd5: green duration loaded automatically after reset.
- DEF_Y, 4'd2: yellow duration loaded automatically after reset.
- DEF_R, 4'd6: red duration loaded automatically after reset.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command this cycle
- cmd_op  in  2  opcode: 00 NOP, 01 SET, 10 STOP, 11 JUMP
- cmd_data  in  3*CNT_W  SET: {G,Y,R} from MSB to LSB; STOP: bit0 = 1 hold, 0 release; ignored otherwise
- err_clr  in  1  clears err_o
- set_o  out  1  one-cycle Set pulse to the controller
- stop_o  out  1  Stop level to the controller
- jump_o  out  1  one-cycle Jump pulse to the controller
- gin_o, yin_o, rin_o  out  CNT_W each  registered durations to the controller
- err_o  out  1  sticky flag: a SET was rejected

Behaviour:
- Clocking and reset: clk is the clock; reset is asynchronous, active-high.
- Reset values: set_o=0, stop_o=0, jump_o=0, gin_o/yin_o/rin_o=DEF_G/DEF_Y/DEF_R, err_o=0, pending_jump=0, state=INIT, cmd_ready=0.
- State machine, INIT -> IDLE: on the first clk edge after reset deasserts, set_o<=1 and state<=IDLE. set_o is therefore high for exactly the first IDLE cycle.
- State machine, IDLE: the block stays in IDLE until reset. cmd_ready = (state==IDLE), combinational from state only and never from cmd_valid.
- Handshake: a command is accepted on the edge where cmd_valid & cmd_ready. All effects are registered, so outputs change at that edge and are visible in the following cycle (latency 1). One command per cycle; back-to-back accepts are allowed.
- Pulse outputs: set_o and jump_o default to 0 every cycle unless asserted by the rules below.
- SET:
  - If any of the G, Y or R fields equals 0: reject. No set_o, durations unchanged, err_o<=1.
  - Otherwise: gin_o/yin_o/rin_o<=fields, set_o<=1, pending_jump<=0.
  - Durations hold until the next accepted SET.
- STOP: stop_o<=cmd_data[0]. Stop does not cancel a pending jump.
- JUMP:
  - If stop_o==0: jump_o<=1.
  - Otherwise: pending_jump<=1. Repeated JUMPs while pending merge into one.
- Pending release: whenever pending_jump==1 and stop_o==0 at an edge, jump_o<=1 and pending_jump<=0. This gives a Jump pulse in the cycle after Stop drops.
- Simultaneous events:
  - An accepted valid SET at the same edge as a pending release: SET wins, pending is cleared, jump_o=0.
  - An accepted JUMP at the same edge as a pending release: a single jump_o pulse.
  - set_o and jump_o are never high in the same cycle.
- NOP: accepted, no effect.
- err_clr: err_o<=0. If err_clr and a rejected SET occur at the same edge, err_o<=1.
- Reset mid-operation: all state returns to reset values immediately; the default SET is reissued after release.

Optional Feature:
- Macro: TLS_CMD_STATUS_EN.
- Defined:
  - Adds output acc_cnt[7:0]: accepted commands, saturating at 255.
  - Adds output rej_cnt[7:0]: rejected SETs, saturating at 255.
  - Both reset to 0; err_clr does not clear them.
- Undefined: the ports and their logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package tls_pkg:
  - Opcode constants OP_NOP, OP_SET, OP_STOP, OP_JUMP.
  - CNT_W default.
  - State enum {INIT, IDLE}.
  - Default duration constants.
- One sub-module, tls_cmd_decode (combinational):
  - Splits cmd_data into G/Y/R fields.
  - Produces is_set_ok, is_set_bad, is_stop, is_jump.
- The top holds registers, pending logic and the optional counters.

Test Plan:
- Reset released -> set_o=1 in the first IDLE cycle with gin/yin/rin=5/2/6; cmd_ready=1 from that cycle on; cmd_ready=0 during reset and INIT.
- SET {3,1,4} accepted at edge E -> durations=3/1/4 and set_o=1 for exactly the cycle after E; err_o stays 0.
- SET {0,2,2} -> no set_o, durations unchanged, err_o=1 and sticky; err_clr next cycle -> err_o=0; rej_cnt=1 with TLS_CMD_STATUS_EN.
- STOP(1), JUMP, JUMP, STOP(0) back-to-back -> stop_o high for 3 cycles, jump_o=0 while stopped, then exactly one jump_o pulse in the cycle after stop_o falls.
- STOP(1), JUMP, STOP(0) then SET {2,2,2} accepted at the pending-release edge -> set_o=1, jump_o stays 0, pending cleared.
- Assert reset while stop_o=1 and a jump is pending -> stop_o=0 and pending cleared immediately; after release, the default SET pulse reappears and no jump_o.
